regfile_scoreboard: RTL and testbench

Register-file scoreboard and issue controller that sits between the decode stage and the execute stage of the RV32I pipeline. It tracks in-flight writes to x1–x31 with per-register pending counters and holds decode whenever a source register has an outstanding write. It also holds decode for write-count saturation and for drain requests. Writebacks retire pending writes, and a flush clears all tracking.

---
 rtl/regfile_scoreboard.sv | 141 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters gating decode issue.
// Optional REGFILE_SCOREBOARD_PERF_EN adds stall_cycles and issue_count outputs.
module regfile_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_writes_rd,
    output logic       id_ready,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    input  logic       drain_req,
    output logic       drain_done,
    output logic       busy,
    output logic       err
`ifdef REGFILE_SCOREBOARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] issue_count
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic [CNT_W-1:0]  cnt [32];
    logic [31:0]       inc;
    logic [31:0]       dec;
    logic [31:0]       nz;
    logic              haz1;
    logic              haz2;
    logic              sat;
    logic              issue;
    logic              spurious;

    always_comb begin
        nz = '0;
        for (int r = 1; r < 32; r++) begin
            nz[r] = (cnt[r] != '0);
        end
    end

    assign busy = |nz;

    assign haz1 = id_uses_rs1 && (id_rs1 != 5'd0) && nz[id_rs1];
    assign haz2 = id_uses_rs2 && (id_rs2 != 5'd0) && nz[id_rs2];
    assign sat  = id_writes_rd && (id_rd != 5'd0) &&
                  (cnt[id_rd] == {CNT_W{1'b1}});

    assign id_ready = run && !haz1 && !haz2 && !sat && !flush;
    assign issue    = id_valid && id_ready;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r] = issue && id_writes_rd && (id_rd == 5'(r));
            dec[r] = wb_valid && (wb_rd == 5'(r));
        end
    end

    // Writeback with nothing in flight is a protocol error; flush squashes it.
    assign spurious = !flush && wb_valid && (wb_rd != 5'd0) && !nz[wb_rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec[r] && !inc[r] && nz[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (spurious) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (drain_req) state_nxt = DRAIN;
            DRAIN:   if (!busy)     state_nxt = DRAINED;
            DRAINED: if (!drain_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        run        = 1'b0;
        drain_done = 1'b0;
        unique case (state)
            RUN:     run = 1'b1;
            DRAIN:   run = 1'b0;
            DRAINED: drain_done = 1'b1;
            default: run = 1'b0;
        endcase
    end

`ifdef REGFILE_SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else begin
            if (id_valid && !id_ready) stall_cycles <= stall_cycles + 32'd1;
            if (issue)                 issue_count  <= issue_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default CNT_W=2).
// Covers RAW, same-cycle issue/retire, saturation, flush, err and drain FSM.
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_writes_rd;
    logic       id_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic       drain_req;
    logic       drain_done;
    logic       busy;
    logic       err;
`ifdef REGFILE_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] issue_count;
`endif

    int tests = 0;
    int fails = 0;

    regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_writes_rd (id_writes_rd),
        .id_ready     (id_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .busy         (busy),
        .err          (err)
`ifdef REGFILE_SCOREBOARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .issue_count  (issue_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        id_rd        = 5'd0;
        id_writes_rd = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        flush        = 1'b0;
    endtask

    task automatic wr(input logic [4:0] rd);
        idle();
        id_valid     = 1'b1;
        id_rd        = rd;
        id_writes_rd = 1'b1;
    endtask

    task automatic rd1(input logic [4:0] rs);
        idle();
        id_uses_rs1 = 1'b1;
        id_rs1      = rs;
    endtask

    task automatic probe_wr(input logic [4:0] rd);
        idle();
        id_rd        = rd;
        id_writes_rd = 1'b1;
    endtask

    initial begin
        idle();
        drain_req = 1'b0;
        rst = 1'b0;
        #2;
        rd1(5'd5);
        #1;
        chk("rst_ready", id_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", drain_done, 1'b0);
        chk("rst_err", err, 1'b0);
        tick();
        rst = 1'b1;
        idle();

        // RAW on x5
        wr(5'd5);
        #1;
        chk("raw_wr_ready", id_ready, 1'b1);
        tick();
        rd1(5'd5);
        id_valid = 1'b1;
        #1;
        chk("raw_stall", id_ready, 1'b0);
        chk("raw_busy", busy, 1'b1);
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
        chk("raw_no_bypass", id_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("raw_after_wb", id_ready, 1'b1);
        chk("raw_idle_busy", busy, 1'b0);
        tick();

        // same-cycle issue and retire on x7
        wr(5'd7);
        tick();
        wr(5'd7);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1;
        chk("same_ready", id_ready, 1'b1);
        tick();
        idle();
        id_uses_rs2 = 1'b1;
        id_rs2      = 5'd7;
        #1;
        chk("same_busy", busy, 1'b1);
        chk("same_rs2_stall", id_ready, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("same_drained", busy, 1'b0);
        chk("same_rs2_ready", id_ready, 1'b1);
        chk("same_no_err", err, 1'b0);

        // saturation on x3
        for (int i = 0; i < 3; i++) begin
            wr(5'd3);
            #1;
            chk("sat_fill", id_ready, 1'b1);
            tick();
        end
        probe_wr(5'd3);
        #1;
        chk("sat_x3_blocked", id_ready, 1'b0);
        probe_wr(5'd4);
        #1;
        chk("sat_x4_ready", id_ready, 1'b1);
        probe_wr(5'd0);
        #1;
        chk("sat_x0_ready", id_ready, 1'b1);
        rd1(5'd0);
        #1;
        chk("x0_never_hazard", id_ready, 1'b1);

        // flush clears x1, x2 and x3
        wr(5'd1);
        tick();
        wr(5'd2);
        tick();
        rd1(5'd1);
        #1;
        chk("fl_pre_stall", id_ready, 1'b0);
        idle();
        flush = 1'b1;
        #1;
        chk("fl_ready_low", id_ready, 1'b0);
        tick();
        idle();
        #1;
        chk("fl_busy", busy, 1'b0);
        rd1(5'd1);
        id_uses_rs2 = 1'b1;
        id_rs2      = 5'd2;
        #1;
        chk("fl_rd12_ready", id_ready, 1'b1);
        probe_wr(5'd3);
        #1;
        chk("fl_x3_ready", id_ready, 1'b1);

        // spurious writeback
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        tick();
        chk("err_x0", err, 1'b0);
        wb_rd = 5'd9;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("err_set", err, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("err_sticky", err, 1'b1);

        // drain with two writes pending
        wr(5'd10);
        tick();
        wr(5'd11);
        tick();
        idle();
        drain_req = 1'b1;
        #1;
        chk("dr_run_ready", id_ready, 1'b1);
        tick();
        chk("dr_blocked", id_ready, 1'b0);
        chk("dr_not_done", drain_done, 1'b0);
        tick();
        chk("dr_wait", drain_done, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd10;
        tick();
        wb_rd = 5'd11;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("dr_zero_busy", busy, 1'b0);
        chk("dr_last_wb", drain_done, 1'b0);
        tick();
        chk("dr_done", drain_done, 1'b1);
        chk("dr_done_ready", id_ready, 1'b0);
        drain_req = 1'b0;
        #1;
        chk("dr_hold_done", drain_done, 1'b1);
        tick();
        chk("dr_resume_done", drain_done, 1'b0);
        chk("dr_resume_ready", id_ready, 1'b1);

        // flush and drain together
        wr(5'd12);
        tick();
        idle();
        flush     = 1'b1;
        drain_req = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fd_busy", busy, 1'b0);
        chk("fd_drain", drain_done, 1'b0);
        chk("fd_ready", id_ready, 1'b0);
        tick();
        chk("fd_done", drain_done, 1'b1);
        drain_req = 1'b0;
        tick();
        chk("fd_resume", id_ready, 1'b1);

        // reset in the middle of a drain
        wr(5'd13);
        tick();
        idle();
        drain_req = 1'b1;
        tick();
        chk("rd_in_drain", id_ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rd_busy", busy, 1'b0);
        chk("rd_ready", id_ready, 1'b1);
        chk("rd_err", err, 1'b0);
        chk("rd_done", drain_done, 1'b0);
        drain_req = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        rd1(5'd13);
        #1;
        chk("rd_x13_clear", id_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
